// File: rtl/fpnew_lane_iter_div_pkg.sv
// Shared defaults for the lane-side iterative divider.
// Holds parameter defaults only; the FSM state type stays local to the top.
package fpnew_lane_iter_div_pkg;

    localparam int unsigned DefWidth      = 32;
    localparam int unsigned DefBitsPerCyc = 1;

endpackage

// File: rtl/fpnew_lane_div_step.sv
// One restoring shift-subtract step of the lane divider.
// {rem, quo} shifts left one bit, and the new quotient bit is shifted into quo.
module fpnew_lane_div_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] quo_i,
    input  logic [Width-1:0] div_i,
    output logic [Width-1:0] rem_o,
    output logic [Width-1:0] quo_o
);

    logic [Width:0] trial;
    logic [Width:0] diff;
    logic           take;

    // The partial remainder is below the divisor, so W+1 bits hold the difference sign.
    assign trial = {rem_i, quo_i[Width-1]};
    assign diff  = trial - {1'b0, div_i};
    assign take  = ~diff[Width];

    assign rem_o = take ? diff[Width-1:0] : trial[Width-1:0];
    assign quo_o = {quo_i[Width-2:0], take};

endmodule

// File: rtl/fpnew_lane_iter_div.sv
// Lane-side iterative integer divider with a fixed latency of Width/BitsPerCyc cycles.
// Start pulses restart at any time, and flush returns the divider to idle.
module fpnew_lane_iter_div
    import fpnew_lane_iter_div_pkg::*;
#(
    parameter int unsigned Width      = DefWidth,
    parameter int unsigned BitsPerCyc = DefBitsPerCyc
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             op_signed_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             fsm_ready_o,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o,
    output logic             div_by_zero_o,
    output logic             busy_o
);

    localparam int unsigned Iters = Width / BitsPerCyc;
    localparam int unsigned CntW  = $clog2(Iters + 1);
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {Idle, Busy, Done} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] rem_q, quo_q, div_q, dvd_q;
    logic             sgn_op_q, sign_q_q, sign_r_q, dbz_q, ovf_q;

    logic [BitsPerCyc:0][Width-1:0] rem_c;
    logic [BitsPerCyc:0][Width-1:0] quo_c;

    logic             dvd_neg, dvs_neg, last;
    logic [Width-1:0] dvd_abs, dvs_abs;

    assign dvd_neg = op_signed_i & dividend_i[Width-1];
    assign dvs_neg = op_signed_i & divisor_i[Width-1];
    assign dvd_abs = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_abs = dvs_neg ? -divisor_i : divisor_i;
    assign last    = (cnt_q == CntW'(Iters - 1));

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar i = 0; i < BitsPerCyc; i++) begin : g_step
        fpnew_lane_div_step #(
            .Width(Width)
        ) u_step (
            .rem_i(rem_c[i]),
            .quo_i(quo_c[i]),
            .div_i(div_q),
            .rem_o(rem_c[i+1]),
            .quo_o(quo_c[i+1])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush beats start; start beats completion.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = Idle;
        end else if (start_i) begin
            state_d = Busy;
        end else if (state_q == Busy && last) begin
            state_d = Done;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            dvd_q    <= '0;
            sgn_op_q <= 1'b0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= dvd_abs;
            div_q    <= dvs_abs;
            dvd_q    <= dividend_i;
            sgn_op_q <= op_signed_i;
            sign_q_q <= dvd_neg ^ dvs_neg;
            sign_r_q <= dvd_neg;
            dbz_q    <= (divisor_i == '0);
            ovf_q    <= op_signed_i && dividend_i == MinVal && divisor_i == '1;
        end else if (state_q == Busy) begin
            rem_q <= rem_c[BitsPerCyc];
            quo_q <= quo_c[BitsPerCyc];
            cnt_q <= last ? '0 : cnt_q + CntW'(1);
        end
    end

    always_comb begin
        quotient_o  = quo_q;
        remainder_o = rem_q;
        if (dbz_q) begin
            quotient_o  = '1;
            remainder_o = dvd_q;
        end else if (ovf_q) begin
            quotient_o  = MinVal;
            remainder_o = '0;
        end else if (sgn_op_q) begin
            if (sign_q_q) quotient_o = -quo_q;
            if (sign_r_q) remainder_o = -rem_q;
        end
    end

    assign fsm_ready_o   = (state_q != Busy);
    assign busy_o        = (state_q == Busy);
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_fpnew_lane_iter_div.sv
// Scoreboard bench for the lane divider: one-bit and four-bit-per-cycle instances.
// Stimulus pushes expected results; per-instance monitors pop them when ready rises.
module tb_fpnew_lane_iter_div;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start_a = 1'b0, flush_a = 1'b0, sgn_a = 1'b0;
    logic [31:0] dd_a = '0, dv_a = '0;
    logic        ready_a, dbz_a, busy_a;
    logic [31:0] q_a, r_a;

    logic        start_b = 1'b0, flush_b = 1'b0, sgn_b = 1'b0;
    logic [31:0] dd_b = '0, dv_b = '0;
    logic        ready_b, dbz_b, busy_b;
    logic [31:0] q_b, r_b;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    fpnew_lane_iter_div #(.Width(32), .BitsPerCyc(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .flush_i(flush_a),
        .op_signed_i(sgn_a), .dividend_i(dd_a), .divisor_i(dv_a),
        .fsm_ready_o(ready_a), .quotient_o(q_a), .remainder_o(r_a),
        .div_by_zero_o(dbz_a), .busy_o(busy_a)
    );

    fpnew_lane_iter_div #(.Width(32), .BitsPerCyc(4)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .flush_i(flush_b),
        .op_signed_i(sgn_b), .dividend_i(dd_b), .divisor_i(dv_b),
        .fsm_ready_o(ready_b), .quotient_o(q_b), .remainder_o(r_b),
        .div_by_zero_o(dbz_b), .busy_o(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor for the one-bit instance: low counts cycles since the last accepted start.
    initial begin
        int   low;
        logic prev;
        exp_t e;
        low  = 0;
        prev = 1'b1;
        wait (rst_n == 1'b1);
        forever begin
            @(posedge clk);
            if (rst_n && start_a && !flush_a) low = 0;
            @(negedge clk);
            if (!ready_a) begin
                low++;
            end else if (!prev) begin
                if (qa.size() == 0) begin
                    check("a_spurious_done", 32'(qa.size()), 32'd1);
                end else begin
                    e = qa.pop_front();
                    check("a_quotient", q_a, e.q);
                    check("a_remainder", r_a, e.r);
                    check("a_dbz", 32'(dbz_a), 32'(e.dbz));
                    check("a_busy", 32'(busy_a), 32'd0);
                    if (e.lat >= 0) check("a_latency", 32'(low), 32'(e.lat));
                end
            end
            prev = ready_a;
        end
    end

    initial begin
        int   low;
        logic prev;
        exp_t e;
        low  = 0;
        prev = 1'b1;
        wait (rst_n == 1'b1);
        forever begin
            @(posedge clk);
            if (rst_n && start_b && !flush_b) low = 0;
            @(negedge clk);
            if (!ready_b) begin
                low++;
            end else if (!prev) begin
                if (qb.size() == 0) begin
                    check("b_spurious_done", 32'(qb.size()), 32'd1);
                end else begin
                    e = qb.pop_front();
                    check("b_quotient", q_b, e.q);
                    check("b_remainder", r_b, e.r);
                    check("b_dbz", 32'(dbz_b), 32'(e.dbz));
                    if (e.lat >= 0) check("b_latency", 32'(low), 32'(e.lat));
                end
            end
            prev = ready_b;
        end
    end

    task automatic issue_a(input logic sgn, input logic [31:0] dd,
                           input logic [31:0] dv);
        sgn_a   = sgn;
        dd_a    = dd;
        dv_a    = dv;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (!ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_wait", 32'(ready_a), 32'd1);
    endtask

    task automatic run_a(input logic sgn, input logic [31:0] dd, input logic [31:0] dv,
                         input logic [31:0] eq, input logic [31:0] er, input logic ed);
        exp_t e;
        e = '{q: eq, r: er, dbz: ed, lat: 32};
        qa.push_back(e);
        issue_a(sgn, dd, dv);
        wait_ready_a();
    endtask

    task automatic run_b(input logic sgn, input logic [31:0] dd, input logic [31:0] dv,
                         input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        int   n;
        e = '{q: eq, r: er, dbz: 1'b0, lat: 8};
        qb.push_back(e);
        sgn_b   = sgn;
        dd_b    = dd;
        dv_b    = dv;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!ready_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b_ready_wait", 32'(ready_b), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_quotient", q_a, 32'd0);
        check("rst_remainder", r_a, 32'd0);
        check("rst_dbz", 32'(dbz_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back operations, each started while the previous sits in DONE.
        run_a(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_a(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_a(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_a(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_a(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_a(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        run_a(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_a(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);
        run_a(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run_a(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);

        // Flush in the tenth busy cycle.
        e = '{q: 32'd0, r: 32'd0, dbz: 1'b0, lat: -1};
        qa.push_back(e);
        issue_a(1'b0, 32'd1000, 32'd10);
        repeat (9) @(negedge clk);
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        wait_ready_a();

        // Flush together with start from DONE: nothing starts, results clear.
        run_a(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        flush_a = 1'b1;
        start_a = 1'b1;
        dd_a    = 32'd50;
        dv_a    = 32'd5;
        @(negedge clk);
        flush_a = 1'b0;
        start_a = 1'b0;
        check("fs_ready", 32'(ready_a), 32'd1);
        check("fs_busy", 32'(busy_a), 32'd0);
        check("fs_quotient", q_a, 32'd0);
        check("fs_remainder", r_a, 32'd0);
        repeat (3) @(negedge clk);
        check("fs_still_idle", 32'(ready_a), 32'd1);

        // Restart in the fifth busy cycle; only the second result is expected.
        e = '{q: 32'd15, r: 32'd2, dbz: 1'b0, lat: 32};
        qa.push_back(e);
        issue_a(1'b0, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        issue_a(1'b0, 32'd77, 32'd5);
        wait_ready_a();

        // Reset in the middle of a divide-by-zero operation.
        e = '{q: 32'd0, r: 32'd0, dbz: 1'b0, lat: -1};
        qa.push_back(e);
        issue_a(1'b1, 32'd5, 32'd0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready_a();

        run_b(1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0);
        run_b(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_b(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6);

        n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 32'(qa.size() + qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
